// File: rtl/benes_sel_sequencer_pkg.sv
// Shared parameters, bank type and FSM encoding for the Benes select sequencer.
// sel_bank_t matches the interconnect input struct so the select arrays connect directly.
package benes_sel_sequencer_pkg;

    localparam int SIZE       = 32;
    localparam int SWITCH_NUM = SIZE / 2;
    localparam int STAGE_NUM  = 2 * $clog2(SIZE) - 1;
    localparam int STG_W      = $clog2(STAGE_NUM);
    localparam int MASK_W     = 2 * STAGE_NUM;

    typedef logic [SWITCH_NUM-1:0] sel_bank_t [0:STAGE_NUM-1];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2,
        ST_WAVE  = 2'd3
    } seq_state_e;

    // Loaded-mask bit for one (path, stage) entry: module path first, slot path above it.
    function automatic logic [MASK_W-1:0] mask_onehot(input logic path,
                                                      input logic [STG_W-1:0] stage);
        logic [MASK_W-1:0] one;
        one = {{(MASK_W-1){1'b0}}, 1'b1};
        if (path) begin
            return one << (STAGE_NUM + int'(stage));
        end else begin
            return one << stage;
        end
    endfunction

endpackage

// File: rtl/benes_sel_sequencer_if.sv
// Route-load and commit handshake between the route controller and the sequencer.
interface benes_sel_sequencer_if;

    logic                                             cfg_valid;
    logic                                             cfg_ready;
    logic                                             cfg_path;
    logic [benes_sel_sequencer_pkg::STG_W-1:0]        cfg_stage;
    logic [benes_sel_sequencer_pkg::SWITCH_NUM-1:0]   cfg_bits;
    logic                                             commit_valid;
    logic                                             commit_ready;

    modport master (
        output cfg_valid, cfg_path, cfg_stage, cfg_bits, commit_valid,
        input  cfg_ready, commit_ready
    );

    modport slave (
        input  cfg_valid, cfg_path, cfg_stage, cfg_bits, commit_valid,
        output cfg_ready, commit_ready
    );

endinterface

// File: rtl/benes_sel_sequencer_bank.sv
// Shadow + active select storage for one path; the active side is filled one stage
// per cycle by the wavefront index so it tracks the one-register-per-stage datapath.
module benes_sel_bank
    import benes_sel_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [STG_W-1:0]      wr_stage_i,
    input  logic [SWITCH_NUM-1:0] wr_bits_i,
    input  logic                  xfer_en_i,
    input  logic [STG_W-1:0]      xfer_idx_i,
    output sel_bank_t             active_o
);

    sel_bank_t shadow_q;
    sel_bank_t active_q;

    // Shadow write port and wavefront copy of one stage into the active bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGE_NUM; s++) begin
                shadow_q[s] <= '0;
                active_q[s] <= '0;
            end
        end else begin
            if (wr_en_i) begin
                shadow_q[wr_stage_i] <= wr_bits_i;
            end
            if (xfer_en_i) begin
                active_q[xfer_idx_i] <= shadow_q[xfer_idx_i];
            end
        end
    end

    assign active_o = active_q;

endmodule

// File: rtl/benes_sel_sequencer.sv
// Benes switch-select sequencer: loads a route into shadow banks, then commits it to
// the active selects as a stage-skewed wavefront.
module benes_sel_sequencer
    import benes_sel_sequencer_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    benes_sel_sequencer_if.slave         cfg_if,
    output sel_bank_t                    o_module_select,
    output sel_bank_t                    o_slot_select,
    output logic                         o_busy,
    output logic                         o_wave_done,
    output logic                         o_err
);

    seq_state_e         state_q, state_d;
    logic [MASK_W-1:0]  mask_q, mask_d;
    logic [STG_W-1:0]   k_q, k_d;
    logic               err_q, busy_q, done_q;
    logic               cfg_ready_q, commit_ready_q;

    logic               wr_acc_s, wr_ok_s, wr_bad_s, commit_s, last_s, xfer_s;

    // Handshake qualification; out-of-range stages are consumed but never stored.
    always_comb begin
        wr_acc_s = cfg_if.cfg_valid & cfg_ready_q;
        wr_ok_s  = wr_acc_s & (cfg_if.cfg_stage < STG_W'(STAGE_NUM));
        wr_bad_s = wr_acc_s & ~(cfg_if.cfg_stage < STG_W'(STAGE_NUM));
        commit_s = cfg_if.commit_valid & commit_ready_q;
        xfer_s   = (state_q == ST_WAVE);
        last_s   = xfer_s & (k_q == STG_W'(STAGE_NUM - 1));
    end

    // Next-state, loaded mask and wavefront counter.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        if (wr_ok_s) begin
            mask_d = mask_q | mask_onehot(cfg_if.cfg_path, cfg_if.cfg_stage);
        end else begin
            mask_d = mask_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (wr_ok_s) begin
                    state_d = (&mask_d) ? ST_ARMED : ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (&mask_d) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_ARMED: begin
                if (commit_s) begin
                    state_d = ST_WAVE;
                    k_d     = '0;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_WAVE: begin
                if (last_s) begin
                    state_d = ST_IDLE;
                    mask_d  = '0;
                    k_d     = '0;
                end else begin
                    k_d     = k_q + STG_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                mask_d  = '0;
                k_d     = '0;
            end
        endcase
    end

    // FSM state plus registered status and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            mask_q         <= '0;
            k_q            <= '0;
            err_q          <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            cfg_ready_q    <= 1'b1;
            commit_ready_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            mask_q         <= mask_d;
            k_q            <= k_d;
            err_q          <= err_q | wr_bad_s;
            busy_q         <= (state_d == ST_WAVE);
            done_q         <= last_s;
            cfg_ready_q    <= (state_d != ST_WAVE);
            commit_ready_q <= (state_d == ST_ARMED);
        end
    end

    assign cfg_if.cfg_ready    = cfg_ready_q;
    assign cfg_if.commit_ready = commit_ready_q;
    assign o_busy              = busy_q;
    assign o_wave_done         = done_q;
    assign o_err               = err_q;

    benes_sel_bank u_module_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_ok_s & ~cfg_if.cfg_path),
        .wr_stage_i (cfg_if.cfg_stage),
        .wr_bits_i  (cfg_if.cfg_bits),
        .xfer_en_i  (xfer_s),
        .xfer_idx_i (k_q),
        .active_o   (o_module_select)
    );

    benes_sel_bank u_slot_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_ok_s & cfg_if.cfg_path),
        .wr_stage_i (cfg_if.cfg_stage),
        .wr_bits_i  (cfg_if.cfg_bits),
        .xfer_en_i  (xfer_s),
        .xfer_idx_i (k_q),
        .active_o   (o_slot_select)
    );

endmodule

// File: tb/tb_benes_sel_sequencer.sv
// Self-checking bench for benes_sel_sequencer: table-driven route load, scoreboarded
// wavefront, and hand-written corner sequences (partial load, error, mid-wave reset).
module tb_benes_sel_sequencer;
    import benes_sel_sequencer_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    sel_bank_t mod_sel, slot_sel;
    logic      busy, wave_done, err;

    benes_sel_sequencer_if ifc ();

    benes_sel_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_if          (ifc),
        .o_module_select (mod_sel),
        .o_slot_select   (slot_sel),
        .o_busy          (busy),
        .o_wave_done     (wave_done),
        .o_err           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        path;
        logic [3:0]  stage;
        logic [15:0] bits;
        logic        exp_commit_ready;
    } vec_t;

    typedef struct {
        int          stage;
        logic [15:0] m;
        logic [15:0] s;
    } sb_t;

    vec_t      tbl [18];
    sb_t       sbq [$];
    sel_bank_t sh_m, sh_s, act_m, act_s, old_m, old_s;
    int        n_cmp = 0;
    int        n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int s = 0; s < STAGE_NUM; s++) begin
            chk({tag, "_mod"}, 32'(mod_sel[s]), 32'(act_m[s]));
            chk({tag, "_slot"}, 32'(slot_sel[s]), 32'(act_s[s]));
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the write edge.
    task automatic cfg_write(input logic p, input logic [3:0] st, input logic [15:0] b);
        ifc.cfg_valid = 1'b1;
        ifc.cfg_path  = p;
        ifc.cfg_stage = st;
        ifc.cfg_bits  = b;
        @(posedge clk);
        #1;
        ifc.cfg_valid = 1'b0;
        if (int'(st) < STAGE_NUM) begin
            if (p) sh_s[st] = b;
            else   sh_m[st] = b;
        end
    endtask

    task automatic load_route(input logic [15:0] ms, input logic [15:0] ss, input int skip);
        for (int i = 0; i < 2 * STAGE_NUM; i++) begin
            if (i != skip) begin
                if (i < STAGE_NUM) cfg_write(1'b0, 4'(i), ms ^ (16'h0001 << i));
                else cfg_write(1'b1, 4'(i - STAGE_NUM), ss ^ (16'h8000 >> (i - STAGE_NUM)));
            end
        end
    endtask

    task automatic commit_wave(input bit sim_wr, input bit hold_cfg);
        int waited;
        sb_t e;
        waited = 0;
        ifc.commit_valid = 1'b1;
        while (!ifc.commit_ready && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("commit_accept", 32'(ifc.commit_ready), 32'd1);
        chk("commit_latency", 32'(waited), 32'd0);
        if (!ifc.commit_ready) begin
            ifc.commit_valid = 1'b0;
            return;
        end
        if (sim_wr) begin
            ifc.cfg_valid = 1'b1;
            ifc.cfg_path  = 1'b0;
            ifc.cfg_stage = 4'd0;
            ifc.cfg_bits  = 16'hFFFF;
            sh_m[0]       = 16'hFFFF;
        end
        old_m = act_m;
        old_s = act_s;
        for (int s = 0; s < STAGE_NUM; s++) begin
            e.stage = s; e.m = sh_m[s]; e.s = sh_s[s];
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        ifc.commit_valid = 1'b0;
        ifc.cfg_valid    = hold_cfg;
        ifc.cfg_path     = 1'b0;
        ifc.cfg_stage    = 4'd1;
        ifc.cfg_bits     = 16'hDEAD;
        for (int c = 0; c <= STAGE_NUM + 1; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            chk("wave_busy", 32'(busy), 32'(c < STAGE_NUM));
            chk("wave_done", 32'(wave_done), 32'(c == STAGE_NUM));
            chk("wave_cfg_ready", 32'(ifc.cfg_ready), 32'(c >= STAGE_NUM));
            chk("wave_commit_ready", 32'(ifc.commit_ready), 32'd0);
            if (c == STAGE_NUM) ifc.cfg_valid = 1'b0;
            if (c >= 1 && c <= STAGE_NUM && sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("wave_new_mod", 32'(mod_sel[e.stage]), 32'(e.m));
                chk("wave_new_slot", 32'(slot_sel[e.stage]), 32'(e.s));
            end
            if (c >= 1 && c < STAGE_NUM) begin
                chk("wave_old_mod", 32'(mod_sel[c]), 32'(old_m[c]));
                chk("wave_old_slot", 32'(slot_sel[c]), 32'(old_s[c]));
            end
        end
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        act_m = sh_m;
        act_s = sh_s;
    endtask

    initial begin
        for (int s = 0; s < STAGE_NUM; s++) begin
            sh_m[s] = '0; sh_s[s] = '0; act_m[s] = '0; act_s[s] = '0;
        end
        for (int i = 0; i < 2 * STAGE_NUM; i++) begin
            tbl[i].path             = (i >= STAGE_NUM);
            tbl[i].stage            = 4'(i % STAGE_NUM);
            tbl[i].bits             = (i < STAGE_NUM) ? (16'h0001 << i)
                                                      : (16'h8000 >> (i - STAGE_NUM));
            tbl[i].exp_commit_ready = (i == 2 * STAGE_NUM - 1);
        end
        ifc.cfg_valid = 1'b0; ifc.cfg_path = 1'b0; ifc.cfg_stage = '0;
        ifc.cfg_bits = '0; ifc.commit_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state.
        check_all("rst");
        chk("rst_cfg_ready", 32'(ifc.cfg_ready), 32'd1);
        chk("rst_commit_ready", 32'(ifc.commit_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_done", 32'(wave_done), 32'd0);

        // Table-driven full load, then committed wavefront.
        for (int i = 0; i < 2 * STAGE_NUM; i++) begin
            chk("tbl_cfg_ready", 32'(ifc.cfg_ready), 32'd1);
            cfg_write(tbl[i].path, tbl[i].stage, tbl[i].bits);
            chk("tbl_commit_ready", 32'(ifc.commit_ready), 32'(tbl[i].exp_commit_ready));
        end
        commit_wave(1'b0, 1'b0);

        // 17 words only: commit held high must not be taken.
        load_route(16'hA5A5, 16'h3C3C, 17);
        ifc.commit_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("partial_commit_ready", 32'(ifc.commit_ready), 32'd0);
        end
        chk("partial_busy", 32'(busy), 32'd0);
        check_all("partial_unchanged");
        cfg_write(1'b1, 4'd8, 16'h1357);
        chk("arm_on_18th", 32'(ifc.commit_ready), 32'd1);
        commit_wave(1'b0, 1'b0);

        // Config write on the commit edge joins the wave.
        load_route(16'h0F0F, 16'hF0F0, -1);
        commit_wave(1'b1, 1'b0);

        // Out-of-range stage: sticky error, mask untouched; cfg held during wave.
        load_route(16'h1111, 16'h2222, STAGE_NUM + 3);
        cfg_write(1'b0, 4'd12, 16'h1234);
        chk("err_set", 32'(err), 32'd1);
        chk("err_no_arm", 32'(ifc.commit_ready), 32'd0);
        cfg_write(1'b1, 4'd3, 16'h4444);
        chk("err_arm", 32'(ifc.commit_ready), 32'd1);
        commit_wave(1'b0, 1'b1);
        chk("err_sticky", 32'(err), 32'd1);

        // Reset in wave cycle 4 abandons the wave.
        load_route(16'h7777, 16'h9999, -1);
        ifc.commit_valid = 1'b1;
        @(posedge clk);
        #1;
        ifc.commit_valid = 1'b0;
        chk("abort_busy_pre", 32'(busy), 32'd1);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int s = 0; s < STAGE_NUM; s++) begin
            sh_m[s] = '0; sh_s[s] = '0; act_m[s] = '0; act_s[s] = '0;
        end
        check_all("abort");
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_route(16'hC001, 16'h0C0D, -1);
        commit_wave(1'b0, 1'b0);
        check_all("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
